// File: rtl/prio_enc_arb.sv
// Registered N-input priority encoder with a valid/ready output handshake.
// Define PRIO_ENC_ARB_RR_EN to select round-robin instead of fixed lowest-index priority.
module prio_enc_arb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic         req_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_multi
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    logic           r_valid;
    logic [W-1:0]   r_idx;
    logic           r_multi;

    logic           w_capture;
    logic [W-1:0]   w_sel;
    logic           w_multi;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic is_multi(input logic [N-1:0] v);
        return |(v & (v - ONE_N));
    endfunction

`ifdef PRIO_ENC_ARB_RR_EN
    logic [W-1:0]   r_ptr;
    logic           w_accept;
    logic [W-1:0]   w_ptr_next;
    logic [W-1:0]   w_start;

    // First set bit at or above start, wrapping from N-1 back to 0.
    function automatic logic [W-1:0] first_rr(input logic [N-1:0] v, input logic [W-1:0] start);
        logic [W-1:0] idx;
        logic         found;
        int           j;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (!found && v[j]) begin
                idx   = W'(j);
                found = 1'b1;
            end else begin
                idx   = idx;
            end
        end
        return idx;
    endfunction

    // Pointer advance on acceptance; a grant accepted this cycle also steers a same-cycle capture.
    always_comb begin
        w_accept   = r_valid && out_ready;
        w_ptr_next = (r_idx == W'(N - 1)) ? {W{1'b0}} : (r_idx + W'(1));
        if (w_accept) begin
            w_start = w_ptr_next;
        end else begin
            w_start = r_ptr;
        end
    end
`else
    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic logic [W-1:0] first_fixed(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = v[i] ? W'(i) : idx;
        end
        return idx;
    endfunction
`endif

    // Handshake qualifiers and the selection for a capture this cycle.
    always_comb begin
        req_ready = (r_state == IDLE) || out_ready;
        w_capture = en && (|req) && req_ready;
        w_multi   = is_multi(req);
`ifdef PRIO_ENC_ARB_RR_EN
        w_sel     = first_rr(req, w_start);
`else
        w_sel     = first_fixed(req);
`endif
    end

    // Control FSM with registered result; HOLD keeps the result stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_multi <= 1'b0;
`ifdef PRIO_ENC_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                        r_idx   <= w_sel;
                        r_multi <= w_multi;
                    end else begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
`ifdef PRIO_ENC_ARB_RR_EN
                        r_ptr <= w_ptr_next;
`endif
                        if (w_capture) begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                            r_idx   <= w_sel;
                            r_multi <= w_multi;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end else begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_multi = r_multi;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb (N=8 and N=5) with a behavioural reference model.
module tb_prio_enc_arb;

`ifdef PRIO_ENC_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en_a, ordy_a, rdy_a, val_a, multi_a;
    logic [7:0] req_a;
    logic [2:0] idx_a;
    logic       en_b, ordy_b, rdy_b, val_b, multi_b;
    logic [4:0] req_b;
    logic [2:0] idx_b;

    int vectors     = 0;
    int miscompares = 0;

    bit m_valid [2];
    int m_idx   [2];
    bit m_multi [2];
    int m_start [2];

    prio_enc_arb #(.N(8)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .req(req_a), .req_ready(rdy_a),
        .out_valid(val_a), .out_ready(ordy_a), .out_idx(idx_a), .out_multi(multi_a)
    );

    prio_enc_arb #(.N(5)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .req(req_b), .req_ready(rdy_b),
        .out_valid(val_b), .out_ready(ordy_b), .out_idx(idx_b), .out_multi(multi_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First set request scanning upward from start, modulo n.
    function automatic int pick(input logic [7:0] r, input int n, input int start);
        int  res;
        bit  found;
        res   = 0;
        found = 1'b0;
        for (int k = 0; k < n; k++) begin
            int j;
            j = (start + k) % n;
            if (!found && r[j]) begin
                res   = j;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Reference model: one pending result per instance plus the next search start.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic [7:0] r;
            bit         e, o, rdy, cap, acc;
            int         n, st;
            r   = (u == 0) ? req_a : {3'b000, req_b};
            e   = (u == 0) ? en_a : en_b;
            o   = (u == 0) ? ordy_a : ordy_b;
            n   = (u == 0) ? 8 : 5;
            rdy = !m_valid[u] || o;
            cap = e && (r != 8'h00) && rdy;
            acc = m_valid[u] && o;
            st  = m_start[u];
            if (acc && RR) st = (m_idx[u] + 1) % n;
            if (rst) begin
                m_valid[u] <= 1'b0;
                m_idx[u]   <= 0;
                m_multi[u] <= 1'b0;
                m_start[u] <= 0;
            end else begin
                m_start[u] <= st;
                if (cap) begin
                    m_valid[u] <= 1'b1;
                    m_idx[u]   <= pick(r, n, st);
                    m_multi[u] <= ($countones(r) > 1);
                end else if (acc) begin
                    m_valid[u] <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("a_valid", int'(val_a), int'(m_valid[0]));
        chk("a_req_ready", int'(rdy_a), int'(!m_valid[0] || ordy_a));
        if (m_valid[0]) begin
            chk("a_idx", int'(idx_a), m_idx[0]);
            chk("a_multi", int'(multi_a), int'(m_multi[0]));
        end
        chk("b_valid", int'(val_b), int'(m_valid[1]));
        chk("b_req_ready", int'(rdy_b), int'(!m_valid[1] || ordy_b));
        if (m_valid[1]) begin
            chk("b_idx", int'(idx_b), m_idx[1]);
            chk("b_multi", int'(multi_b), int'(m_multi[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b1; req_a = 8'hFF; ordy_a = 1'b1;
        en_b = 1'b0; req_b = 5'b00000; ordy_b = 1'b1;

        for (int c = 0; c < 2; c++) begin
            cyc();
            chk("rst_valid", int'(val_a), 0);
            chk("rst_idx", int'(idx_a), 0);
            chk("rst_multi", int'(multi_a), 0);
            chk("rst_req_ready", int'(rdy_a), 1);
        end
        rst = 1'b0;
        cyc();
        chk("first_valid", int'(val_a), 1);
        chk("first_idx", int'(idx_a), 0);
        chk("first_multi", int'(multi_a), 1);

        for (int k = 0; k < 8; k++) begin
            req_a = 8'h01 << k;
            cyc();
            chk("onehot_idx", int'(idx_a), k);
            chk("onehot_multi", int'(multi_a), 0);
        end
        req_a = 8'b0010_0100;
        cyc();
        chk("multihot_idx", int'(idx_a), 2);
        chk("multihot_multi", int'(multi_a), 1);

        req_a = 8'h04;
        cyc();
        chk("bp_cap_idx", int'(idx_a), 2);
        ordy_a = 1'b0; req_a = 8'h80;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("bp_valid", int'(val_a), 1);
            chk("bp_idx", int'(idx_a), 2);
            chk("bp_req_ready", int'(rdy_a), 0);
        end
        ordy_a = 1'b1;
        cyc();
        chk("bp_next_idx", int'(idx_a), 7);
        req_a = 8'h00;
        cyc();
        chk("bp_drain_valid", int'(val_a), 0);

        en_a = 1'b0; req_a = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("en0_valid", int'(val_a), 0);
        end
        en_a = 1'b1; req_a = 8'h00;
        for (int c = 0; c < 2; c++) begin
            cyc();
            chk("empty_valid", int'(val_a), 0);
        end
        req_a = 8'h08;
        cyc();
        chk("hold_en_idx", int'(idx_a), 3);
        ordy_a = 1'b0; en_a = 1'b0; req_a = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            cyc();
            chk("hold_en_valid", int'(val_a), 1);
            chk("hold_en_idx2", int'(idx_a), 3);
        end
        ordy_a = 1'b1;
        cyc();
        chk("hold_en_done", int'(val_a), 0);

        en_a = 1'b1; req_a = 8'h10;
        cyc();
        chk("mid_cap_idx", int'(idx_a), 4);
        ordy_a = 1'b0;
        cyc();
        chk("mid_stall_valid", int'(val_a), 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", int'(val_a), 0);
        chk("mid_rst_idx", int'(idx_a), 0);
        rst = 1'b0; req_a = 8'h00; ordy_a = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            chk("mid_after_valid", int'(val_a), 0);
        end

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        en_b = 1'b1; req_b = 5'b10001;
        for (int g = 0; g < 4; g++) begin
            cyc();
            chk("n5_idx", int'(idx_b), RR ? ((g % 2 == 1) ? 4 : 0) : 0);
        end
        en_b = 1'b0; req_b = 5'b00000;

        rst = 1'b1;
        cyc();
        rst = 1'b0; req_a = 8'hFF; en_a = 1'b1; ordy_a = 1'b1;
        for (int g = 0; g < 3; g++) begin
            cyc();
            chk("rr_idx", int'(idx_a), RR ? g : 0);
        end
        ordy_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("rr_stall_idx", int'(idx_a), RR ? 2 : 0);
        end
        ordy_a = 1'b1;
        for (int g = 3; g < 9; g++) begin
            cyc();
            chk("rr_resume_idx", int'(idx_a), RR ? (g % 8) : 0);
        end

        req_a = 8'h00;
        cyc();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
